// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-programming controller.
package combo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int              DIGW          = 8;
  localparam logic [DIGW-1:0] NO_MATCH      = 8'hFF;
  localparam int              NDIG_DFLT     = 3;
  localparam logic [23:0]     DEF_CODE_DFLT = 24'h12_34_56;
  localparam int              TW            = 16;

endpackage

// File: rtl/combo_prog_ctrl_ms_timer.sv
// Loadable millisecond down-counter; expired_o pulses on the last counted cycle.
module ms_timer
  import combo_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] value_i,
  output logic          expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TW'(1));

endmodule

// File: rtl/combo_prog_ctrl.sv
// Safe combination-programming controller; captures new digits and muxes the stored code.
// Optional fail lockout is enabled by defining COMBO_LOCKOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a qualified prog edge
// CAPT   | capturing one digit per direction change
// COMMIT | shadow copied into the stored code
module combo_prog_ctrl
  import combo_pkg::*;
#(
  parameter int                     NDIG       = NDIG_DFLT,
  parameter logic [NDIG*DIGW-1:0]   DEF_CODE   = DEF_CODE_DFLT,
  parameter int                     TIMEOUT_MS = 10000,
  parameter int                     MAX_FAIL   = 3,
  parameter int                     LOCKOUT_MS = 30000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       prog_i,
  input  logic       unlocked_i,
  input  logic       doorCls_i,
  input  logic       dirch_i,
  input  logic [3:0] bcd0_i,
  input  logic [3:0] bcd1_i,
  input  logic [1:0] sel_i,
  input  logic       fail_i,
  output logic [3:0] code0_o,
  output logic [3:0] code1_o,
  output logic       progActive_o,
  output logic       progDone_o,
  output logic       clrCount_o,
  output logic       lockout_o
);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [NDIG*DIGW-1:0] shadow_q, shadow_d;
  logic [NDIG*DIGW-1:0] stored_q, stored_d;
  logic                 prog_q, active_q, done_q, done_d, clr_q, clr_d;
  logic                 prog_rise, abort, tmo_load, tmo_exp, lockout_w;
  logic [DIGW-1:0]      code_sel;

  assign prog_rise = prog_i & ~prog_q;
  assign abort     = doorCls_i | ~unlocked_i | prog_rise | tmo_exp;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    stored_d = stored_q;
    clr_d    = 1'b0;
    done_d   = 1'b0;
    tmo_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prog_rise && unlocked_i && !doorCls_i && !lockout_w) begin
          state_d  = CAPT;
          idx_d    = 2'd0;
          tmo_load = 1'b1;
          clr_d    = 1'b1;
        end
      end
      CAPT: begin
        if (abort) begin
          state_d  = IDLE;
          shadow_d = '0;
        end else if (dirch_i) begin
          for (int i = 0; i < NDIG; i++)
            if (idx_q == 2'(i)) shadow_d[i*DIGW +: DIGW] = {bcd1_i, bcd0_i};
          clr_d    = 1'b1;
          tmo_load = 1'b1;
          if (idx_q == 2'(NDIG-1)) begin
            state_d = COMMIT;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      COMMIT: begin
        stored_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The edge-detect flop follows the button even in reset, so a held button is not an edge.
  always_ff @(posedge clk_i) prog_q <= prog_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      stored_q <= DEF_CODE;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      stored_q <= stored_d;
      active_q <= (state_d != IDLE);
      done_q   <= done_d;
      clr_q    <= clr_d;
    end
  end

  ms_timer u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmo_load),
    .value_i   (TW'(TIMEOUT_MS)),
    .expired_o (tmo_exp)
  );

  always_comb begin
    code_sel = NO_MATCH;
    for (int i = 0; i < NDIG; i++)
      if (sel_i == 2'(i)) code_sel = stored_q[i*DIGW +: DIGW];
  end

  assign code0_o      = code_sel[3:0];
  assign code1_o      = code_sel[7:4];
  assign progActive_o = active_q;
  assign progDone_o   = done_q;
  assign clrCount_o   = clr_q;
  assign lockout_o    = lockout_w;

`ifdef COMBO_LOCKOUT_EN
  logic       lock_q, unl_q, unl_rise, lock_load, lock_exp;
  logic [7:0] fail_cnt_q;

  assign unl_rise  = unlocked_i & ~unl_q;
  assign lock_load = fail_i && !lock_q && !lock_exp && !unl_rise &&
                     (fail_cnt_q == 8'(MAX_FAIL-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      unl_q      <= 1'b0;
      fail_cnt_q <= 8'd0;
    end else begin
      unl_q <= unlocked_i;
      if (lock_exp && lock_q) begin
        lock_q     <= 1'b0;
        fail_cnt_q <= 8'd0;
      end else if (unl_rise) begin
        fail_cnt_q <= 8'd0;
      end else if (fail_i && !lock_q) begin
        fail_cnt_q <= fail_cnt_q + 8'd1;
        if (lock_load) lock_q <= 1'b1;
      end
    end
  end

  ms_timer u_lock (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (lock_load),
    .value_i   (TW'(LOCKOUT_MS)),
    .expired_o (lock_exp)
  );

  assign lockout_w = lock_q;
`else
  logic unused_lock;
  assign unused_lock = ^{fail_i, 32'(MAX_FAIL), 32'(LOCKOUT_MS)};
  assign lockout_w   = 1'b0;
`endif

endmodule

// File: tb/tb_combo_prog_ctrl.sv
// Self-checking bench for combo_prog_ctrl: scoreboarded code reads plus pulse/timing checks.
module tb_combo_prog_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i, prog_i, unlocked_i, doorCls_i, dirch_i, fail_i;
  logic [3:0] bcd0_i, bcd1_i, code0_o, code1_o;
  logic [1:0] sel_i;
  logic       progActive_o, progDone_o, clrCount_o, lockout_o;

  int n_chk = 0;
  int n_err = 0;
  int clr_seen = 0;
  int done_seen = 0;
  logic [7:0] model [0:2];
  logic [7:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  combo_prog_ctrl #(
    .NDIG(3), .DEF_CODE(24'h12_34_56), .TIMEOUT_MS(20), .MAX_FAIL(3), .LOCKOUT_MS(50)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prog_i(prog_i), .unlocked_i(unlocked_i),
    .doorCls_i(doorCls_i), .dirch_i(dirch_i), .bcd0_i(bcd0_i), .bcd1_i(bcd1_i),
    .sel_i(sel_i), .fail_i(fail_i), .code0_o(code0_o), .code1_o(code1_o),
    .progActive_o(progActive_o), .progDone_o(progDone_o), .clrCount_o(clrCount_o),
    .lockout_o(lockout_o)
  );

  always @(negedge clk_i) begin
    if (!rst_i && clrCount_o) clr_seen++;
    if (!rst_i && progDone_o) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_codes(input string tag);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? model[i] : 8'hFF);
      sel_i = 2'(i);
      #1;
      chk(tag, {code1_o, code0_o}, exp_q.pop_front());
    end
  endtask

  task automatic start(input string tag);
    prog_i = 1'b1;
    step();
    prog_i = 1'b0;
    chk({tag, "_active"}, progActive_o, 1'b1);
    chk({tag, "_clr"}, clrCount_o, 1'b1);
  endtask

  task automatic capture(input logic [7:0] bcd);
    bcd0_i  = bcd[3:0];
    bcd1_i  = bcd[7:4];
    dirch_i = 1'b1;
    step();
    dirch_i = 1'b0;
  endtask

  initial begin
    int clr0, done0, n;
    logic seen_active;
    rst_i = 1'b1; prog_i = 1'b1; unlocked_i = 1'b1; doorCls_i = 1'b0;
    dirch_i = 1'b0; fail_i = 1'b0; bcd0_i = 4'h0; bcd1_i = 4'h0; sel_i = 2'd0;
    model[0] = 8'h56; model[1] = 8'h34; model[2] = 8'h12;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    step();
    chk("rst_active", progActive_o, 1'b0);
    chk("rst_done", progDone_o, 1'b0);
    chk("rst_clr", clrCount_o, 1'b0);
    chk("rst_lockout", lockout_o, 1'b0);
    chk("rst_held_prog_clrs", clr_seen, 0);
    check_codes("rst_code");
    prog_i = 1'b0;
    step();

    // full programming
    clr0 = clr_seen; done0 = done_seen;
    start("full_start");
    capture(8'h07);
    chk("full_clr1", clrCount_o, 1'b1);
    capture(8'h42);
    capture(8'h99);
    chk("full_done", progDone_o, 1'b1);
    chk("full_active_commit", progActive_o, 1'b1);
    sel_i = 2'd0; #1;
    chk("full_old_code_n1", {code1_o, code0_o}, 8'h56);
    step();
    chk("full_done_end", progDone_o, 1'b0);
    chk("full_active_end", progActive_o, 1'b0);
    chk("full_clr_cnt", clr_seen - clr0, 4);
    chk("full_done_cnt", done_seen - done0, 1);
    model[0] = 8'h07; model[1] = 8'h42; model[2] = 8'h99;
    check_codes("full_code");

    // abort by door closing after two captures
    done0 = done_seen;
    start("door_start");
    capture(8'h11);
    capture(8'h22);
    doorCls_i = 1'b1;
    step();
    chk("door_active", progActive_o, 1'b0);
    doorCls_i = 1'b0;
    repeat (3) step();
    chk("door_done_cnt", done_seen - done0, 0);
    check_codes("door_code");

    // dirch and unlocked drop together on the last digit
    done0 = done_seen;
    start("sim_start");
    capture(8'h31);
    capture(8'h32);
    bcd0_i = 4'h3; bcd1_i = 4'h3; dirch_i = 1'b1; unlocked_i = 1'b0;
    step();
    dirch_i = 1'b0;
    chk("sim_active", progActive_o, 1'b0);
    chk("sim_clr", clrCount_o, 1'b0);
    chk("sim_done", progDone_o, 1'b0);
    unlocked_i = 1'b1;
    repeat (3) step();
    chk("sim_done_cnt", done_seen - done0, 0);
    check_codes("sim_code");

    // a second prog edge aborts
    done0 = done_seen;
    start("reprog_start");
    capture(8'h55);
    prog_i = 1'b1;
    step();
    prog_i = 1'b0;
    chk("reprog_active", progActive_o, 1'b0);
    step();
    chk("reprog_done_cnt", done_seen - done0, 0);

    // prog edges ignored while locked or with door closed
    clr0 = clr_seen;
    unlocked_i = 1'b0; prog_i = 1'b1;
    step();
    prog_i = 1'b0;
    step();
    chk("locked_prog_active", progActive_o, 1'b0);
    unlocked_i = 1'b1; doorCls_i = 1'b1; prog_i = 1'b1;
    step();
    prog_i = 1'b0;
    step();
    chk("door_prog_active", progActive_o, 1'b0);
    chk("ignored_prog_clrs", clr_seen - clr0, 0);
    doorCls_i = 1'b0;
    step();

    // timeout: active for exactly TIMEOUT_MS cycles with no dirch
    done0 = done_seen;
    start("tmo_start");
    n = 0;
    while (progActive_o && n < 100) begin
      n++;
      step();
    end
    chk("tmo_cycles", n, 20);
    chk("tmo_done_cnt", done_seen - done0, 0);
    check_codes("tmo_code");

    // fail lockout
    repeat (3) begin
      fail_i = 1'b1;
      step();
      fail_i = 1'b0;
      step();
    end
`ifdef COMBO_LOCKOUT_EN
    n = 0; seen_active = 1'b0;
    while (lockout_o && n < 100) begin
      n++;
      fail_i = (n == 10);
      prog_i = (n >= 20 && n < 25);
      seen_active = seen_active | progActive_o;
      step();
    end
    fail_i = 1'b0; prog_i = 1'b0;
    chk("lock_cycles", n, 50);
    chk("lock_prog_ignored", seen_active, 1'b0);
    fail_i = 1'b1;
    step();
    fail_i = 1'b0;
    step();
    chk("lock_counter_cleared", lockout_o, 1'b0);
`else
    n = 0;
    repeat (10) begin
      if (lockout_o) n++;
      step();
    end
    chk("nolock_lockout", n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
